// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, state encoding, Rcon and S-box tables for the key-expansion g-function
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        XOR  = 2'd2,
        OUT  = 2'd3
    } keyg_state_t;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_SUB  = 2'(SUB);
    localparam logic [1:0] ST_XOR  = 2'(XOR);
    localparam logic [1:0] ST_OUT  = 2'(OUT);

    localparam byte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam byte_t SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox_lookup(input byte_t b);
        return SBOX_TABLE[b];
    endfunction

    // Out-of-range rounds map to zero so the S-box result passes through unmodified.
    function automatic byte_t rcon_for(input logic [3:0] round);
        byte_t r;
        r = 8'h00;
        case (round)
            4'd1:  r = RCON[1];
            4'd2:  r = RCON[2];
            4'd3:  r = RCON[3];
            4'd4:  r = RCON[4];
            4'd5:  r = RCON[5];
            4'd6:  r = RCON[6];
            4'd7:  r = RCON[7];
            4'd8:  r = RCON[8];
            4'd9:  r = RCON[9];
            4'd10: r = RCON[10];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    assign sbox_out = sbox_lookup(sbox_in);

endmodule

// File: rtl/aes_key_g_func.sv
// rtl/aes_key_g_func.sv - key-expansion g-function (RotWord, SubWord, Rcon); AES_KEYG_PARALLEL_SBOX_EN selects four S-boxes
module aes_key_g_func
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        areset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic [3:0]  in_round,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err
);

    logic [1:0]  state;
    logic [31:0] sub_word;
    logic [3:0]  round_q;

    assign in_ready = areset_n && (state == ST_IDLE);

`ifdef AES_KEYG_PARALLEL_SBOX_EN
    logic [31:0] sbox_word;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .sbox_in  (sub_word[8*g +: 8]),
            .sbox_out (sbox_word[8*g +: 8])
        );
    end
`else
    logic [1:0] byte_cnt;
    logic [7:0] sbox_in;
    logic [7:0] sbox_out;

    // byte_cnt 0 selects byte3, counting down to byte0.
    always_comb begin
        sbox_in = sub_word[31:24];
        case (byte_cnt)
            2'd0: sbox_in = sub_word[31:24];
            2'd1: sbox_in = sub_word[23:16];
            2'd2: sbox_in = sub_word[15:8];
            2'd3: sbox_in = sub_word[7:0];
            default: sbox_in = sub_word[31:24];
        endcase
    end

    aes_sbox u_sbox (
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out)
    );
`endif

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state     <= ST_IDLE;
            sub_word  <= 32'h0;
            round_q   <= 4'h0;
            out_valid <= 1'b0;
            out_word  <= 32'h0;
            out_err   <= 1'b0;
`ifndef AES_KEYG_PARALLEL_SBOX_EN
            byte_cnt  <= 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sub_word <= {in_word[23:0], in_word[31:24]};
                        round_q  <= in_round;
                        state    <= ST_SUB;
`ifndef AES_KEYG_PARALLEL_SBOX_EN
                        byte_cnt <= 2'd0;
`endif
                    end
                end
                ST_SUB: begin
`ifdef AES_KEYG_PARALLEL_SBOX_EN
                    sub_word <= sbox_word;
                    state    <= ST_XOR;
`else
                    case (byte_cnt)
                        2'd0: sub_word[31:24] <= sbox_out;
                        2'd1: sub_word[23:16] <= sbox_out;
                        2'd2: sub_word[15:8]  <= sbox_out;
                        2'd3: sub_word[7:0]   <= sbox_out;
                        default: sub_word[31:24] <= sbox_out;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state <= ST_XOR;
                    end
`endif
                end
                ST_XOR: begin
                    out_word  <= sub_word ^ {rcon_for(round_q), 24'h0};
                    out_err   <= (round_q == 4'd0) || (round_q > 4'd10);
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_g_func.sv
// tb/tb_aes_key_g_func.sv - scoreboard bench for aes_key_g_func; latency expectation follows AES_KEYG_PARALLEL_SBOX_EN
module tb_aes_key_g_func;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [3:0]  in_round;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;

`ifdef AES_KEYG_PARALLEL_SBOX_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 6;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic [32:0] exp_q [$];

    aes_key_g_func dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one input, hold it until accepted, then queue its expected result.
    task automatic send(input logic [31:0] w, input logic [3:0] r,
                        input logic [31:0] ew, input logic ee);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = w;
        in_round = r;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1 acc_cyc = cyc;
        exp_q.push_back({ee, ew});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("out_valid_timeout", 32'(ok), 32'd1);
    endtask

    // The accepting edge is counted as the first edge of the latency.
    task automatic compare_out(input string tag, input bit check_lat);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_word"}, out_word, e[31:0]);
            chk({tag, "_err"}, 32'(out_err), 32'(e[32]));
        end
        if (check_lat) chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(EXP_LAT));
    endtask

    task automatic recv(input string tag, input bit check_lat);
        @(negedge clk);
        wait_out();
        compare_out(tag, check_lat);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    logic [7:0] rc_tab [1:10];
    logic [31:0] held;
    int spurious;

    initial begin
        rc_tab = '{8'h62, 8'h61, 8'h67, 8'h6b, 8'h73, 8'h43, 8'h23, 8'he3, 8'h78, 8'h55};
        areset_n  = 1'b0;
        in_valid  = 1'b0;
        in_word   = 32'h0;
        in_round  = 4'd0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        areset_n = 1'b1;
        #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

        // FIPS-197 vectors and boundary rounds
        send(32'h09cf4f3c, 4'd1, 32'h8b84eb01, 1'b0);
        recv("w3_r1", 1'b1);
        send(32'h2a6c7605, 4'd2, 32'h52386be5, 1'b0);
        recv("w7_r2", 1'b1);
        send(32'h0, 4'd10, 32'h55636363, 1'b0);
        recv("w0_r10", 1'b0);
        send(32'h0, 4'd11, 32'h63636363, 1'b1);
        recv("w0_r11", 1'b0);
        send(32'h0, 4'd0, 32'h63636363, 1'b1);
        recv("w0_r0", 1'b0);
        send(32'h0, 4'd15, 32'h63636363, 1'b1);
        recv("w0_r15", 1'b0);
        for (int r = 1; r <= 9; r++) begin
            send(32'h0, 4'(r), {rc_tab[r], 24'h636363}, 1'b0);
            recv("w0_rtab", 1'b0);
        end

        // Backpressure: output held, next input waits for the handshake
        out_ready = 1'b0;
        send(32'h09cf4f3c, 4'd1, 32'h8b84eb01, 1'b0);
        @(negedge clk);
        wait_out();
        compare_out("hold_first", 1'b0);
        held = out_word;
        in_valid = 1'b1;
        in_word  = 32'h0;
        in_round = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_word", out_word, held);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 acc_cyc = cyc;
        exp_q.push_back({1'b0, 32'h67636363});
        @(negedge clk);
        in_valid = 1'b0;
        chk("hs_accepted", 32'(in_ready), 32'd0);
        recv("hold_second", 1'b1);

        // Reset during SUB abandons the transaction
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 32'h09cf4f3c;
        in_round = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        areset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        #1 chk("midrst_rel_in_ready", 32'(in_ready), 32'd1);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("midrst_no_output", 32'(spurious), 32'd0);
        send(32'h0, 4'd1, 32'h62636363, 1'b0);
        recv("post_rst", 1'b1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
